// File: rtl/ddr_pkg.sv
// Shared types for the ACT/CAS scheduler: request kinds, DDR address layout,
// FSM state encoding and a few helpers.
package ddr_pkg;

    localparam int BANK_W = 4;
    localparam int ROW_W  = 14;
    localparam int COL_W  = 10;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        RD_R  = 2'd0,
        WR_R  = 2'd1,
        RDA_R = 2'd2,
        WRA_R = 2'd3
    } request_type;

    typedef struct packed {
        logic [1:0]       bg;
        logic [1:0]       ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } mem_addr_type;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE      = 3'd1,
        WAIT_RP  = 3'd2,
        ACT      = 3'd3,
        WAIT_RCD = 3'd4,
        CAS      = 3'd5,
        WAIT_GAP = 3'd6
    } sched_state_t;

    function automatic logic is_auto_pre(request_type t);
        return (t == RDA_R) || (t == WRA_R);
    endfunction

    function automatic logic [BANK_W-1:0] bank_of(mem_addr_type a);
        return {a.bg, a.ba};
    endfunction

endpackage

// File: rtl/act_cas_sched_if.sv
// Host request / command strobe bundle of the ACT/CAS scheduler.
interface act_cas_sched_if;
    import ddr_pkg::*;

    // Handshake: a request transfers on a rising edge where req_valid=1 and
    // busy=0; while busy=1 req_* are ignored (no queuing), so the host simply
    // holds its request until it sees busy low.
    logic         req_valid;
    request_type  req_type;
    mem_addr_type req_addr;

    logic         busy;
    logic         act_rdy;
    logic         no_act_rdy;
    logic         pre_rdy;
    logic         cas_rdy;
    mem_addr_type cmd_addr;
    request_type  cmd_type;
    sched_state_t state;

    modport master (
        output req_valid, req_type, req_addr,
        input  busy, act_rdy, no_act_rdy, pre_rdy, cas_rdy, cmd_addr, cmd_type, state
    );

    modport slave (
        input  req_valid, req_type, req_addr,
        output busy, act_rdy, no_act_rdy, pre_rdy, cas_rdy, cmd_addr, cmd_type, state
    );

endinterface

// File: rtl/open_row_table.sv
// Per-bank open-row tracker: 16 banks indexed by {bg,ba}, combinational lookup,
// open/close write ports and a synchronous clear of all open flags.
module open_row_table
    import ddr_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic [BANK_W-1:0] lk_bank,
    output logic              lk_open,
    output logic [ROW_W-1:0]  lk_row,
    input  logic              open_en,
    input  logic [BANK_W-1:0] open_bank,
    input  logic [ROW_W-1:0]  open_row,
    input  logic              close_en,
    input  logic [BANK_W-1:0] close_bank
);

    logic [(1<<BANK_W)-1:0] open_q;
    logic [ROW_W-1:0]       row_q [1<<BANK_W];

    // Row values need no clear: they are only meaningful while the open flag is set.
    always_ff @(posedge clk) begin
        if (clr) begin
            open_q <= '0;
        end else begin
            if (open_en)  open_q[open_bank]  <= 1'b1;
            if (close_en) open_q[close_bank] <= 1'b0;
        end
        if (open_en) row_q[open_bank] <= open_row;
    end

    assign lk_open = open_q[lk_bank];
    assign lk_row  = row_q[lk_bank];

endmodule

// File: rtl/act_cas_sched.sv
// Single-request ACT/CAS scheduler with tRCD/tRP/tCCD/tRTP spacing.
// OPEN_PAGE_EN enables open-row tracking; otherwise every access is closed-page.
module act_cas_sched
    import ddr_pkg::*;
#(
    parameter int TRCD = 11,
    parameter int TRP  = 11,
    parameter int TCCD = 4,
    parameter int TRTP = 6
) (
    input logic           CK_t,
    input logic           reset_n,
    act_cas_sched_if.slave bus
);

    // Each delay counts from the strobe cycle itself; the post-CAS gap spans
    // TCCD-1 cycles including the CAS cycle, never less than one.
    localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] RTP_LD = CNT_W'(TRTP - 1);
    localparam logic [CNT_W-1:0] GAP_LD = (TCCD >= 2) ? CNT_W'(TCCD - 2) : '0;

    sched_state_t     state_q;
    logic             busy_q, act_q, noact_q, pre_q, cas_q;
    mem_addr_type     addr_q;
    request_type      type_q;
    logic [CNT_W-1:0] cnt;
    logic             closing;
    logic             ap_tail;
    logic             bank_open, row_hit;

`ifdef OPEN_PAGE_EN
    localparam bit CLOSED_PAGE = 1'b0;
    logic             lk_open;
    logic [ROW_W-1:0] lk_row;

    open_row_table u_table (
        .clk        (CK_t),
        .clr        (!reset_n),
        .lk_bank    (bank_of(bus.req_addr)),
        .lk_open    (lk_open),
        .lk_row     (lk_row),
        .open_en    (act_q),
        .open_bank  (bank_of(addr_q)),
        .open_row   (addr_q.row),
        .close_en   (pre_q || (cas_q && is_auto_pre(type_q))),
        .close_bank (bank_of(addr_q))
    );

    assign bank_open = lk_open;
    assign row_hit   = lk_open && (lk_row == bus.req_addr.row);
`else
    localparam bit CLOSED_PAGE = 1'b1;
    assign bank_open = 1'b0;
    assign row_hit   = 1'b0;
`endif

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            act_q   <= 1'b0;
            noact_q <= 1'b0;
            pre_q   <= 1'b0;
            cas_q   <= 1'b0;
            addr_q  <= '0;
            type_q  <= RD_R;
            cnt     <= '0;
            closing <= 1'b0;
            ap_tail <= 1'b0;
        end else begin
            act_q   <= 1'b0;
            noact_q <= 1'b0;
            pre_q   <= 1'b0;
            cas_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        busy_q  <= 1'b1;
                        addr_q  <= bus.req_addr;
                        type_q  <= bus.req_type;
                        closing <= 1'b0;
                        ap_tail <= 1'b0;
                        if (row_hit) begin
                            noact_q <= 1'b1;
                            state_q <= ACT;
                            cnt     <= '0;
                        end else if (bank_open) begin
                            pre_q   <= 1'b1;
                            state_q <= PRE;
                            cnt     <= RP_LD;
                        end else begin
                            act_q   <= 1'b1;
                            state_q <= ACT;
                            cnt     <= RCD_LD;
                        end
                    end
                end
                // A closing precharge (closed-page tail) ends the request instead of re-activating.
                PRE, WAIT_RP: begin
                    if (cnt == '0) begin
                        if (closing) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            act_q   <= 1'b1;
                            state_q <= ACT;
                            cnt     <= RCD_LD;
                        end
                    end else begin
                        cnt     <= cnt - 1'b1;
                        state_q <= WAIT_RP;
                    end
                end
                ACT, WAIT_RCD: begin
                    if (cnt == '0) begin
                        cas_q   <= 1'b1;
                        state_q <= CAS;
                        if (is_auto_pre(type_q)) begin
                            cnt     <= GAP_LD;
                            ap_tail <= 1'b1;
                        end else if (CLOSED_PAGE) begin
                            cnt     <= RTP_LD;
                            closing <= 1'b1;
                        end else begin
                            cnt     <= GAP_LD;
                        end
                    end else begin
                        cnt     <= cnt - 1'b1;
                        state_q <= WAIT_RCD;
                    end
                end
                // ap_tail appends a tRP phase; closing hands over to an explicit PRE.
                CAS, WAIT_GAP: begin
                    if (cnt == '0) begin
                        if (ap_tail) begin
                            ap_tail <= 1'b0;
                            cnt     <= RP_LD;
                            state_q <= WAIT_GAP;
                        end else if (closing) begin
                            pre_q   <= 1'b1;
                            state_q <= PRE;
                            cnt     <= RP_LD;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt     <= cnt - 1'b1;
                        state_q <= WAIT_GAP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.act_rdy    = act_q;
    assign bus.no_act_rdy = noact_q;
    assign bus.pre_rdy    = pre_q;
    assign bus.cas_rdy    = cas_q;
    assign bus.cmd_addr   = addr_q;
    assign bus.cmd_type   = type_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_act_cas_sched.sv
// Directed bench for act_cas_sched; strobe cycles are counted from the acceptance
// edge N (k=1 is the cycle after N). Open-page steps are built with OPEN_PAGE_EN.
module tb_act_cas_sched;
    import ddr_pkg::*;

    localparam int TRCD  = 11;
    localparam int TRP   = 11;
    localparam int TCCD  = 4;
    localparam int TRTP  = 6;
    localparam int LIMIT = 100;

    logic CK_t    = 1'b0;
    logic reset_n = 1'b0;

    act_cas_sched_if bus();

    act_cas_sched #(.TRCD(TRCD), .TRP(TRP), .TCCD(TCCD), .TRTP(TRTP)) dut (
        .CK_t    (CK_t),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 CK_t = ~CK_t;

    int total = 0;
    int bad   = 0;
    int t_act, t_noact, t_pre, t_cas, t_idle;
    int n_act, n_noact, n_pre, n_cas, n_multi;
    mem_addr_type cas_addr, pre_addr, exp_addr;
    request_type  cas_type;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        t_act = -1; t_noact = -1; t_pre = -1; t_cas = -1; t_idle = -1;
        n_act = 0; n_noact = 0; n_pre = 0; n_cas = 0; n_multi = 0;
        cas_addr = '0; pre_addr = '0; cas_type = RD_R;
    endtask

    task automatic sample(input int k);
        int s;
        s = int'(bus.act_rdy) + int'(bus.no_act_rdy) + int'(bus.pre_rdy) + int'(bus.cas_rdy);
        if (s > 1) n_multi++;
        if (bus.act_rdy) begin n_act++; if (t_act < 0) t_act = k; end
        if (bus.no_act_rdy) begin n_noact++; if (t_noact < 0) t_noact = k; end
        if (bus.pre_rdy) begin
            n_pre++;
            if (t_pre < 0) begin t_pre = k; pre_addr = bus.cmd_addr; end
        end
        if (bus.cas_rdy) begin
            n_cas++;
            if (t_cas < 0) begin t_cas = k; cas_addr = bus.cmd_addr; cas_type = bus.cmd_type; end
        end
    endtask

    // Called at a negedge; returns at the negedge of the first idle cycle.
    // While hold is pending, req_valid stays high with a different request.
    task automatic run_req(input request_type t, input logic [1:0] g, input logic [1:0] b,
                           input logic [13:0] row, input int hold);
        clear_obs();
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_addr  = '{bg: g, ba: b, row: row, col: 10'h015};
        @(posedge CK_t);
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge CK_t);
            if (k >= hold) begin
                bus.req_valid = 1'b0;
            end else begin
                bus.req_type     = WR_R;
                bus.req_addr.row = row ^ 14'h3fff;
            end
            sample(k);
            if (!bus.busy) begin
                t_idle = k;
                break;
            end
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_type  = RD_R;
        bus.req_addr  = '0;
        reset_n       = 1'b0;
        repeat (3) @(posedge CK_t);
        @(negedge CK_t);
        check("rst_busy", bus.busy, 0);
        check("rst_strobes", {bus.act_rdy, bus.no_act_rdy, bus.pre_rdy, bus.cas_rdy}, 0);
        check("rst_cmd_addr", bus.cmd_addr, 0);
        check("rst_cmd_type", bus.cmd_type, RD_R);
        check("rst_state", bus.state, IDLE);
        reset_n = 1'b1;
        @(negedge CK_t);

        // Bank closed RD_R; req_valid held into busy with a different request.
        exp_addr = '{bg: 2'd1, ba: 2'd2, row: 14'h0a5, col: 10'h015};
        run_req(RD_R, 2'd1, 2'd2, 14'h0a5, 3);
        check("rd1_act_cycle", t_act, 1);
        check("rd1_act_count", n_act, 1);
        check("rd1_noact_count", n_noact, 0);
        check("rd1_cas_cycle", t_cas, 1 + TRCD);
        check("rd1_cas_addr", cas_addr, exp_addr);
        check("rd1_cas_type", cas_type, RD_R);
        check("rd1_exclusive", n_multi, 0);
`ifdef OPEN_PAGE_EN
        check("rd1_pre_count", n_pre, 0);
        check("rd1_idle_cycle", t_idle, 1 + TRCD + TCCD - 1);

        // Row hit.
        run_req(RD_R, 2'd1, 2'd2, 14'h0a5, 1);
        check("hit_noact_cycle", t_noact, 1);
        check("hit_act_count", n_act, 0);
        check("hit_cas_cycle", t_cas, 2);
        check("hit_idle_cycle", t_idle, 2 + TCCD - 1);

        // Row miss.
        run_req(WR_R, 2'd1, 2'd2, 14'h0a6, 1);
        check("miss_pre_cycle", t_pre, 1);
        check("miss_act_cycle", t_act, 1 + TRP);
        check("miss_cas_cycle", t_cas, 1 + TRP + TRCD);
        check("miss_cas_type", cas_type, WR_R);
        check("miss_idle_cycle", t_idle, 1 + TRP + TRCD + TCCD - 1);
`else
        check("rd1_pre_cycle", t_pre, 1 + TRCD + TRTP);
        check("rd1_pre_addr", pre_addr, exp_addr);
        check("rd1_idle_cycle", t_idle, 1 + TRCD + TRTP + TRP);

        // Closed-page WR_R: never a row hit, explicit PRE tRTP after CAS.
        exp_addr = '{bg: 2'd1, ba: 2'd2, row: 14'h0a6, col: 10'h015};
        run_req(WR_R, 2'd1, 2'd2, 14'h0a6, 1);
        check("wr_act_cycle", t_act, 1);
        check("wr_noact_count", n_noact, 0);
        check("wr_cas_cycle", t_cas, 1 + TRCD);
        check("wr_pre_cycle", t_pre, 1 + TRCD + TRTP);
        check("wr_pre_addr", pre_addr, exp_addr);
        check("wr_pre_count", n_pre, 1);
        check("wr_idle_cycle", t_idle, 1 + TRCD + TRTP + TRP);
`endif

        // Auto-precharge read: gap extended by tRP, bank left closed.
        run_req(RDA_R, 2'd0, 2'd1, 14'h100, 1);
        check("rda_act_cycle", t_act, 1);
        check("rda_cas_cycle", t_cas, 1 + TRCD);
        check("rda_cas_type", cas_type, RDA_R);
        check("rda_pre_count", n_pre, 0);
        check("rda_idle_cycle", t_idle, 1 + TRCD + TCCD - 1 + TRP);
        run_req(RD_R, 2'd0, 2'd1, 14'h100, 1);
        check("after_rda_act_cycle", t_act, 1);
        check("after_rda_noact_count", n_noact, 0);
        check("after_rda_cas_cycle", t_cas, 1 + TRCD);
`ifdef OPEN_PAGE_EN
        check("after_rda_idle_cycle", t_idle, 1 + TRCD + TCCD - 1);
`else
        check("after_rda_idle_cycle", t_idle, 1 + TRCD + TRTP + TRP);
`endif

        // Reset two cycles into WAIT_RCD abandons the request.
        bus.req_valid = 1'b1;
        bus.req_type  = RD_R;
        bus.req_addr  = '{bg: 2'd3, ba: 2'd3, row: 14'h1234, col: 10'h015};
        @(posedge CK_t);
        @(negedge CK_t);
        bus.req_valid = 1'b0;
        check("rr_act_strobe", bus.act_rdy, 1);
        repeat (2) begin
            @(posedge CK_t);
            @(negedge CK_t);
        end
        check("rr_state_before", bus.state, WAIT_RCD);
        reset_n = 1'b0;
        @(posedge CK_t);
        @(negedge CK_t);
        check("rr_busy", bus.busy, 0);
        check("rr_state", bus.state, IDLE);
        check("rr_strobes", {bus.act_rdy, bus.no_act_rdy, bus.pre_rdy, bus.cas_rdy}, 0);
        reset_n = 1'b1;
        clear_obs();
        for (int k = 1; k <= 20; k++) begin
            @(negedge CK_t);
            sample(k);
        end
        check("rr_quiet_cas", n_cas, 0);
        check("rr_quiet_all", n_act + n_noact + n_pre, 0);
        run_req(RD_R, 2'd3, 2'd3, 14'h1234, 1);
        check("rr_next_act_cycle", t_act, 1);
        check("rr_next_noact_count", n_noact, 0);
        check("rr_next_cas_cycle", t_cas, 1 + TRCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/act_cas_sched.md
ACT_CAS_SCHED -- requirements
Module: act_cas_sched

Interface
REQ-001 SHALL have parameter: TRCD, 11, ACT-to-CAS delay in CK_t cycles (1..31).
REQ-002 SHALL have parameter: TRP, 11, PRE-to-ACT delay in CK_t cycles (1..31).
REQ-003 SHALL have parameter: TCCD, 4, CAS-to-next-request gap in CK_t cycles (1..31).
REQ-004 SHALL have parameter: TRTP, 6, CAS-to-PRE delay in closed-page mode (1..31).
REQ-005 SHALL have ports: CK_t in 1 clock; reset_n in 1 synchronous active-low reset, sampled on CK_t rising edge.
REQ-006 SHALL have ports: req_valid in 1 host request present; req_type in 2 request_type (RD_R/WR_R/RDA_R/WRA_R); req_addr in mem_addr_type (bg 2, ba 2, row 14, col 10).
REQ-007 SHALL have ports: busy out 1 request in flight; act_rdy, no_act_rdy, pre_rdy, cas_rdy out 1 each, single-cycle command strobes.
REQ-008 SHALL have ports: cmd_addr out mem_addr_type, address for current strobe; cmd_type out 2, request type of current strobe.

Function
REQ-009 SHALL accept a request on the rising edge where req_valid=1 and busy=0 in IDLE (acceptance cycle N); busy=1 from N+1 until return to IDLE.
REQ-010 SHALL ignore req_valid while busy=1; no request queuing.
REQ-011 SHALL implement states IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_GAP.
REQ-012 Bank closed: act_rdy at N+1, cas_rdy at N+1+TRCD.
REQ-013 Row hit (bank open, same row): no_act_rdy at N+1, cas_rdy at N+2; no ACT issued.
REQ-014 Row miss (bank open, other row): pre_rdy at N+1, act_rdy at N+1+TRP, cas_rdy at N+1+TRP+TRCD.
REQ-015 All strobes SHALL be registered, one cycle wide, mutually exclusive; cmd_addr/cmd_type valid in strobe cycles, hold last value otherwise.
REQ-016 After cas_rdy, SHALL stay in WAIT_GAP for TCCD-1 cycles, then IDLE; busy deasserts in the first IDLE cycle; earliest next acceptance same cycle.
REQ-017 RDA_R/WRA_R SHALL mark bank closed at cas_rdy and extend WAIT_GAP by TRP cycles.
REQ-018 ACT SHALL record row as open for {bg,ba}; PRE SHALL mark bank closed; 16 banks tracked independently.
REQ-019 Delay counters SHALL be 5-bit, loaded with param-1, decrement to 0; no wrap-around.

Reset
REQ-020 reset_n=0 SHALL, at next CK_t edge: state IDLE, busy=0, all strobes 0, cmd_addr='0, cmd_type=RD_R, all banks closed, counters 0.
REQ-021 Reset mid-operation SHALL abandon the request with no further strobes.

Configuration
REQ-022 With OPEN_PAGE_EN defined: open-row tracking per REQ-013/014/018.
REQ-023 Without OPEN_PAGE_EN: every request takes bank-closed path; after non-auto-precharge CAS, SHALL wait TRTP cycles, emit pre_rdy for same bank, wait TRP, then IDLE; no_act_rdy never asserted.

Structure
REQ-024 request_type, mem_addr_type and sched_state_t enum SHALL live in ddr_pkg.
REQ-025 Open-row table SHALL be sub-module open_row_table (lookup by {bg,ba}, open/close write ports, synchronous clear).

Verification
REQ-026 Reset, RD_R bg=1 ba=2 row=0x0A5 at N, TRCD=11 -> act_rdy N+1, cas_rdy N+12, busy low N+15.
REQ-027 (OPEN_PAGE_EN) second RD_R same bank/row -> no_act_rdy N+1, cas_rdy N+2, no act_rdy.
REQ-028 (OPEN_PAGE_EN) WR_R same bank row=0x0A6, TRP=11 -> pre_rdy N+1, act_rdy N+12, cas_rdy N+23.
REQ-029 RDA_R then RD_R same row -> second takes ACT path; first busy spans TCCD+TRP after CAS.
REQ-030 reset_n low two cycles into WAIT_RCD -> no cas_rdy, busy=0, next same-row request issues act_rdy.
REQ-031 (no OPEN_PAGE_EN) WR_R, TRTP=6 -> cas_rdy C, pre_rdy C+6, busy low C+6+TRP.
